// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token, registered one-hot grant,
// bounded grant hold and a mandatory idle turnaround cycle after every release.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout,
  output logic [N-1:0]   ptr
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [N-1:0]   PTR_RST  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_SAT = {HCW{1'b1}};
  localparam logic [HCW-1:0] HOLD_ONE = {{(HCW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [IDW-1:0] onehot_to_idx(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = {IDW{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = idx | (v[i] ? IDW'(i) : {IDW{1'b0}});
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [N-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      multi = multi | (seen & v[i]);
      seen  = seen | v[i];
    end
    return seen & ~multi;
  endfunction

  // Walks the ring starting at position p and returns the first requester found.
  function automatic logic [IDW-1:0] pick_first(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic           found;
    logic           hit;
    logic [IDW-1:0] g;
    logic [IDW-1:0] k;
    found = 1'b0;
    g     = {IDW{1'b0}};
    for (int i = 0; i < N; i++) begin
      k     = IDW'((int'(p) + i) % N);
      hit   = ~found & r[k];
      g     = hit ? k : g;
      found = found | hit;
    end
    return g;
  endfunction

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDW-1:0] idx);
    return ONE_N << idx;
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  state_t         state_r, state_s;
  logic [N-1:0]   gnt_r, gnt_s;
  logic [IDW-1:0] gnt_id_r, gnt_id_s;
  logic           busy_r, busy_s;
  logic           timeout_r, timeout_s;
  logic [N-1:0]   ptr_r, ptr_s;
  logic [HCW-1:0] hold_cnt_r, hold_cnt_s;
  logic [N-1:0]   ptr_safe_s;
  logic [IDW-1:0] win_s;

  // A corrupted token falls back to the reset position instead of stalling arbitration.
  always_comb begin
    ptr_safe_s = is_onehot(ptr_r) ? ptr_r : PTR_RST;
    win_s      = pick_first(req, onehot_to_idx(ptr_safe_s));
  end

  // Next-state and next-output decision.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    gnt_id_s   = gnt_id_r;
    timeout_s  = 1'b0;
    ptr_s      = ptr_safe_s;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (req != {N{1'b0}}) begin
          state_s    = GRANT;
          gnt_s      = idx_to_onehot(win_s);
          gnt_id_s   = win_s;
          ptr_s      = rotl(idx_to_onehot(win_s));
          hold_cnt_s = HOLD_ONE;
        end else begin
          state_s    = IDLE;
          gnt_s      = {N{1'b0}};
          gnt_id_s   = {IDW{1'b0}};
          hold_cnt_s = {HCW{1'b0}};
        end
      end
      GRANT: begin
        if (!req[gnt_id_r]) begin
          state_s    = IDLE;
          gnt_s      = {N{1'b0}};
          gnt_id_s   = {IDW{1'b0}};
          hold_cnt_s = {HCW{1'b0}};
        end else if ((MAX_HOLD != 0) && (hold_cnt_r == HOLD_LIM)) begin
          state_s    = IDLE;
          gnt_s      = {N{1'b0}};
          gnt_id_s   = {IDW{1'b0}};
          timeout_s  = 1'b1;
          hold_cnt_s = {HCW{1'b0}};
        end else if (hold_cnt_r != HOLD_SAT) begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        gnt_s      = {N{1'b0}};
        gnt_id_s   = {IDW{1'b0}};
        ptr_s      = PTR_RST;
        hold_cnt_s = {HCW{1'b0}};
      end
    endcase
    busy_s = |gnt_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      gnt_r      <= {N{1'b0}};
      gnt_id_r   <= {IDW{1'b0}};
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      ptr_r      <= PTR_RST;
      hold_cnt_r <= {HCW{1'b0}};
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      gnt_id_r   <= gnt_id_s;
      busy_r     <= busy_s;
      timeout_r  <= timeout_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;
  assign ptr     = ptr_r;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed, table-driven bench for ring_rr_arbiter (N=4, MAX_HOLD=4) plus hand-written
// multi-cycle sequences for contention timeouts, reset during a grant and 1-cycle pulses.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;
  logic [N-1:0]   ptr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           busy;
    logic           tmo;
    logic [N-1:0]   ptr;
  } vec_t;

  vec_t vq[$];

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout),
    .ptr     (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %b, expected %b", nm, fld, act, exp);
    end
  endtask

  task automatic step_chk(input string nm, input logic r, input logic [N-1:0] rq,
                          input logic [N-1:0] eg, input logic [IDW-1:0] eid,
                          input logic eb, input logic et, input logic [N-1:0] ep);
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
    cmp(nm, "gnt",     8'(gnt),     8'(eg));
    cmp(nm, "gnt_id",  8'(gnt_id),  8'(eid));
    cmp(nm, "busy",    8'(busy),    8'(eb));
    cmp(nm, "timeout", 8'(timeout), 8'(et));
    cmp(nm, "ptr",     8'(ptr),     8'(ep));
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [IDW-1:0] id;
    rst = 1'b0;
    req = 4'b0000;

    // reset held two edges, then release -> requester 3 wins first
    vq.push_back('{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000});
    vq.push_back('{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0001});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001});
    // single requester 2 for three cycles
    vq.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000});
    // fairness: order 3,0,1,2,3, each winner drops after two grant cycles
    vq.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0001});
    vq.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0001});
    vq.push_back('{1'b1, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001});
    vq.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0010});
    vq.push_back('{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0010});
    vq.push_back('{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0010});
    vq.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000});
    vq.push_back('{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0001});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001});
    // requester 1 continuous: 4 grant cycles, timeout, regrant
    vq.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1, 4'b0100});
    vq.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100});

    for (int i = 0; i < vq.size(); i++) begin
      step_chk($sformatf("vec%0d", i), vq[i].rst, vq[i].req,
               vq[i].gnt, vq[i].id, vq[i].busy, vq[i].tmo, vq[i].ptr);
    end

    // contention from reset: 0 and 1 alternate, four cycles each, timeout after each
    step_chk("cont_rst", 1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000);
    for (int r = 0; r < 4; r++) begin
      g  = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      id = (r % 2 == 0) ? 2'd0 : 2'd1;
      p  = (r % 2 == 0) ? 4'b0010 : 4'b0100;
      for (int c = 0; c < 4; c++) begin
        step_chk($sformatf("cont_r%0d_c%0d", r, c), 1'b1, 4'b0011, g, id, 1'b1, 1'b0, p);
      end
      step_chk($sformatf("cont_r%0d_tmo", r), 1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, p);
    end

    // reset on cycle 2 of a grant to requester 2, restart from requester 3
    step_chk("mid2_idle", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100);
    step_chk("mid2_c1",   1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000);
    step_chk("mid2_c2",   1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b1000);
    step_chk("mid2_rst",  1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000);
    step_chk("mid2_rel",  1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0001);

    // reset during a grant to requester 1 must pull ptr back from 0100
    step_chk("mid1_drop", 1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0001);
    step_chk("mid1_gnt",  1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0100);
    step_chk("mid1_rst",  1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000);
    step_chk("mid1_post", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1000);

    // one-edge request pulse gives a single grant cycle
    step_chk("pulse_gnt", 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0010);
    step_chk("pulse_rel", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
